if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding request/response instruction-memory port.
- Applies trap/branch/jal redirects, discards stale in-flight fetches, and presents pc_out/instr_out/instr_valid to IF/ID, which captures when stall is low.

---
 rtl/if_fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding on the imem port,
// and feeds IF/ID. Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_trap,
    input  logic [31:0] trap_target,
    input  logic        flush_branch,
    input  logic [31:0] branch_target,
    input  logic        flush_jal,
    input  logic [31:0] jal_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        drop_r;
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;

    logic        redirect_s;
    logic [31:0] target_sel_s;
    logic [31:0] target_load_s;
    logic        halted_s;
    logic        accept_s;
    logic        resp_s;
    logic        resp_keep_s;

    assign redirect_s  = flush_trap | flush_branch | flush_jal;
    assign imem_req    = (state_r == ST_REQ) && !redirect_s;
    assign imem_addr   = pc_r;
    assign accept_s    = imem_req && imem_ready;
    assign resp_s      = (state_r == ST_WAIT) && imem_rvalid;
    // A response is useful only if no redirect has made it stale.
    assign resp_keep_s = resp_s && !drop_r && !redirect_s;

    // Redirect target priority: trap, then branch, then jal.
    always_comb begin
        target_sel_s = jal_target;
        if (flush_trap) begin
            target_sel_s = trap_target;
        end else if (flush_branch) begin
            target_sel_s = branch_target;
        end else begin
            target_sel_s = jal_target;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic halt_r;
    logic misaligned_r;
    logic misaligned_s;

    assign misaligned_s     = (target_sel_s[1:0] != 2'b00);
    assign target_load_s    = target_sel_s;
    assign halted_s         = halt_r;
    assign fetch_misaligned = misaligned_r;

    // A misaligned redirect parks the unit until the next redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_r       <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            misaligned_r <= redirect_s && misaligned_s;
            if (redirect_s) begin
                halt_r <= misaligned_s;
            end
        end
    end
`else
    assign target_load_s    = target_sel_s & 32'hFFFF_FFFC;
    assign halted_s         = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic for the single-outstanding fetch protocol.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!redirect_s && !skid_valid_r && !halted_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_s) begin
                    state_next_s = ST_IDLE;
                end else if (imem_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // PC, in-flight request PC and stale-response tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            req_pc_r <= RESET_PC;
            drop_r   <= 1'b0;
        end else begin
            if (redirect_s) begin
                pc_r <= target_load_s;
            end else if (accept_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (accept_s) begin
                req_pc_r <= pc_r;
            end
            if (redirect_s && (state_r == ST_WAIT) && !imem_rvalid) begin
                drop_r <= 1'b1;
            end else if (resp_s) begin
                drop_r <= 1'b0;
            end
        end
    end

    // Output slot towards IF/ID plus the one-entry skid behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid  <= 1'b0;
            instr_out    <= NOP_INSTR;
            pc_out       <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= 32'h0000_0000;
        end else if (redirect_s) begin
            instr_valid  <= 1'b0;
            instr_out    <= NOP_INSTR;
            skid_valid_r <= 1'b0;
        end else if (!stall) begin
            if (skid_valid_r) begin
                instr_valid  <= 1'b1;
                instr_out    <= skid_instr_r;
                pc_out       <= skid_pc_r;
                skid_valid_r <= 1'b0;
            end else if (resp_keep_s) begin
                instr_valid <= 1'b1;
                instr_out   <= imem_rdata;
                pc_out      <= req_pc_r;
            end else begin
                instr_valid <= 1'b0;
                instr_out   <= NOP_INSTR;
            end
        end else if (resp_keep_s) begin
            // Stalled: park behind a full slot, otherwise fill the empty slot.
            if (instr_valid) begin
                skid_valid_r <= 1'b1;
                skid_instr_r <= imem_rdata;
                skid_pc_r    <= req_pc_r;
            end else begin
                instr_valid <= 1'b1;
                instr_out   <= imem_rdata;
                pc_out      <= req_pc_r;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios, then randomized traffic
// checked against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush_trap = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic        flush_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        flush_jal = 1'b0;
    logic [31:0] jal_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_misaligned;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .flush_trap(flush_trap), .trap_target(trap_target),
        .flush_branch(flush_branch), .branch_target(branch_target),
        .flush_jal(flush_jal), .jal_target(jal_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // memory model / scoreboard state
    int          cyc = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    int          due = 0;
    int          k_min = 1;
    int          k_max = 1;
    bit          spurious_en = 0;
    bit          late_rvalid = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    bit          halted = 0;
    bit          chk_flush = 0;
    bit          chk_mis = 0;
    bit          prev_stuck = 0;
    logic [31:0] prev_addr = 32'h0;
    int          consumed = 0;
    int          idle_cnt = 0;

    // observations from the most recent tick
    bit          o_acc, o_valid, o_req, o_resp, o_mis;
    logic [31:0] o_acc_addr, o_pc, o_instr, o_resp_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: entered right after a negedge with the inputs already set.
    task automatic tick();
        logic [31:0] sel;
        bit redir;
        o_resp = 0;
        if (late_rvalid) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001; late_rvalid = 0;
        end else if (pend && cyc >= due) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
            o_resp = 1; o_resp_addr = pend_addr; pend = 0;
        end else if (spurious_en && !pend && $urandom_range(0, 15) == 0) begin
            imem_rvalid = 1'b1; imem_rdata = $urandom;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        #1;
        redir = flush_trap | flush_branch | flush_jal;
        o_valid = instr_valid; o_pc = pc_out; o_instr = instr_out;
        o_req = imem_req; o_mis = fetch_misaligned;
        if (!instr_valid) check_eq("nop_when_invalid", instr_out, NOP);
        if (chk_flush) check_eq("flush_clears_valid", instr_valid, 0);
        chk_flush = 0;
        check_eq("misaligned_pulse", fetch_misaligned, chk_mis);
        chk_mis = 0;
        if (redir) check_eq("no_req_on_redirect", imem_req, 0);
        else if (prev_stuck) begin
            check_eq("req_held", imem_req, 1);
            check_eq("addr_held", imem_addr, prev_addr);
        end
        o_acc = imem_req && imem_ready;
        if (o_acc) begin
            check_eq("single_outstanding", pend, 0);
            check_eq("no_fetch_while_halted", halted, 0);
            check_eq("fetch_addr", imem_addr, exp_fetch);
            pend = 1; pend_addr = imem_addr; o_acc_addr = imem_addr;
            due = cyc + $urandom_range(k_min, k_max);
            exp_fetch = exp_fetch + 32'd4;
        end
        prev_stuck = imem_req && !imem_ready;
        prev_addr = imem_addr;
        if (redir) begin
            sel = flush_trap ? trap_target : (flush_branch ? branch_target : jal_target);
`ifdef IF_MISALIGN_TRAP_EN
            halted = (sel[1:0] != 2'b00);
            chk_mis = halted;
`else
            sel = sel & 32'hFFFF_FFFC;
`endif
            exp_pc = sel; exp_fetch = sel; chk_flush = 1;
        end else if (!stall && instr_valid) begin
            check_eq("pc_order", pc_out, exp_pc);
            check_eq("instr_data", instr_out, mem_word(pc_out));
            exp_pc = exp_pc + 32'd4;
            consumed++; idle_cnt = 0;
        end else begin
            idle_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit late);
        stall = 0; flush_trap = 0; flush_branch = 0; flush_jal = 0; imem_rvalid = 0;
        reset = 1'b1;
        #1;
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_pc", imem_addr, 32'h0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", instr_out, NOP);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_misaligned", fetch_misaligned, 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        pend = 0; exp_pc = 32'h0; exp_fetch = 32'h0; halted = 0;
        chk_flush = 0; chk_mis = 0; prev_stuck = 0; late_rvalid = late;
    endtask

    task automatic run_until_acc(input string tag, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_acc) begin
                got = 1;
                break;
            end
        end
        check_eq(tag, got, 1);
    endtask

    initial begin
        bit seen8;
        bit found;
        @(negedge clk);
        do_reset(0);
        imem_ready = 1'b1;

        // 1: first fetches and response latency
        run_until_acc("t1_first_accept", 10);
        check_eq("t1_addr0", o_acc_addr, 32'h0);
        tick();
        check_eq("t1_valid_after_1", o_valid, 0);
        tick();
        check_eq("t1_valid_after_2", o_valid, 1);
        check_eq("t1_pc", o_pc, 32'h0);
        check_eq("t1_instr", o_instr, 32'h0050_0093);
        run_until_acc("t1_second_accept", 10);
        check_eq("t1_addr4", o_acc_addr, 32'h4);
        tick();

        // 2: stall holds pc 4 while the 0x8 response lands in the skid
        stall = 1;
        seen8 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t2_hold_valid", o_valid, 1);
            check_eq("t2_hold_pc", o_pc, 32'h4);
            if (o_acc) check_eq("t2_addr8", o_acc_addr, 32'h8);
            if (o_resp && o_resp_addr == 32'h8) seen8 = 1;
            if (i >= 2) check_eq("t2_no_req_skid_full", o_req, 0);
        end
        check_eq("t2_resp8_during_stall", seen8, 1);
        stall = 0;
        tick();
        check_eq("t2_release_pc4", o_pc, 32'h4);
        tick();
        check_eq("t2_next_valid", o_valid, 1);
        check_eq("t2_next_pc8", o_pc, 32'h8);

        // 3: branch while waiting on 0x10 drops its response
        k_min = 3; k_max = 3;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_acc && o_acc_addr == 32'h10) begin
                found = 1;
                break;
            end
        end
        check_eq("t3_reach_0x10", found, 1);
        flush_branch = 1; branch_target = 32'h40;
        tick();
        flush_branch = 0;
        tick();
        check_eq("t3_flush_valid", o_valid, 0);
        check_eq("t3_flush_instr", o_instr, NOP);
        run_until_acc("t3_refetch", 20);
        check_eq("t3_addr40", o_acc_addr, 32'h40);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_valid) begin
                found = 1;
                break;
            end
        end
        check_eq("t3_first_valid", found, 1);
        check_eq("t3_first_pc", o_pc, 32'h40);
        k_min = 1; k_max = 1;

        // 4: trap beats jal
        flush_trap = 1; trap_target = 32'h100; flush_jal = 1; jal_target = 32'h80;
        tick();
        flush_trap = 0; flush_jal = 0;
        run_until_acc("t4_refetch", 20);
        check_eq("t4_addr100", o_acc_addr, 32'h100);

        // 5: reset while a request is waiting for ready
        imem_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_req) begin
                found = 1;
                break;
            end
        end
        check_eq("t5_in_req", found, 1);
        do_reset(1);
        imem_ready = 1'b1;
        run_until_acc("t5_restart", 10);
        check_eq("t5_addr0", o_acc_addr, 32'h0);

        // 6: misaligned jal target
        flush_jal = 1; jal_target = 32'h42;
        tick();
        flush_jal = 0;
`ifdef IF_MISALIGN_TRAP_EN
        tick();
        check_eq("t6_mis_pulse", o_mis, 1);
        found = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t6_mis_one_cycle", o_mis, 0);
            if (o_req) found = 1;
        end
        check_eq("t6_no_req", found, 0);
        flush_branch = 1; branch_target = 32'h200;
        tick();
        flush_branch = 0;
        run_until_acc("t6_recover", 20);
        check_eq("t6_addr200", o_acc_addr, 32'h200);
`else
        run_until_acc("t6_refetch", 20);
        check_eq("t6_addr40", o_acc_addr, 32'h40);
`endif

        // randomized traffic against the stream model
        k_min = 1; k_max = 3; spurious_en = 1; consumed = 0; idle_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            stall = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            flush_trap = ($urandom_range(0, 39) == 0);
            flush_branch = ($urandom_range(0, 39) == 0);
            flush_jal = ($urandom_range(0, 39) == 0);
            trap_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
                          | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            branch_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
                            | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            jal_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
                         | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            tick();
            if (idle_cnt > 300) begin
                check_eq("progress_watchdog", idle_cnt, 0);
                break;
            end
        end
        check_eq("random_progress", (consumed > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
